// File: rtl/mux2_rr_arbiter.sv
// Round-robin owner of a shared 2:1 mux with bounded hold. Grant and Select are registered one edge after req.
// out_valid and out are combinational from the grant; out_ready low freezes the beat count and blocks forced rotation.
module mux2_rr_arbiter #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [DW-1:0] in1,
  input  logic          req1,
  input  logic [DW-1:0] in2,
  input  logic          out_ready,
  output logic          gnt0,
  output logic          gnt1,
  output logic          Select,
  output logic [DW-1:0] out,
  output logic          out_valid
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CMAX = CW'(MAX_HOLD);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] G0   = 2'd1;
  localparam logic [1:0] G1   = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_upd;
  logic          last;
  logic          xfer;

  assign gnt0   = (state == G0);
  assign gnt1   = (state == G1);
  assign Select = (state == G1);

  // Outputs are held quiet while reset is asserted, so the aborted cycle carries no transfer.
  assign out_valid = rst_n & ((gnt0 & req0) | (gnt1 & req1));
  assign out       = (!rst_n || state == IDLE) ? '0 : (Select ? in2 : in1);
  assign xfer      = out_valid & out_ready;

  always_comb begin
    cnt_upd = cnt;
    if (xfer && cnt != CMAX)
      cnt_upd = cnt + CW'(1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req0 && req1)
          state_nxt = last ? G0 : G1;
        else if (req0)
          state_nxt = G0;
        else if (req1)
          state_nxt = G1;
        else
          state_nxt = IDLE;
      end
      G0: begin
        if (!req0)
          state_nxt = req1 ? G1 : IDLE;
        else if (req1 && cnt_upd == CMAX)
          state_nxt = G1;
      end
      G1: begin
        if (!req1)
          state_nxt = req0 ? G0 : IDLE;
        else if (req0 && cnt_upd == CMAX)
          state_nxt = G0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        cnt <= '0;
        if (state_nxt == G0)
          last <= 1'b0;
        else if (state_nxt == G1)
          last <= 1'b1;
      end else begin
        cnt <= cnt_upd;
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Directed bench for mux2_rr_arbiter: per-cycle reference model plus a beat scoreboard.
module tb_mux2_rr_arbiter;
  localparam int DW = 8;
  localparam int MH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, out_ready;
  logic [DW-1:0] in1, in2;
  logic          gnt0, gnt1, Select, out_valid;
  logic [DW-1:0] out;

  int passed = 0;
  int total  = 0;

  // reference model: 0 = idle, 1 = owner 0, 2 = owner 1
  int m_st   = 0;
  int m_cnt  = 0;
  int m_last = 1;
  logic [DW-1:0] sb_q[$];

  mux2_rr_arbiter #(.DW(DW), .MAX_HOLD(MH)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .in1(in1), .req1(req1), .in2(in2),
    .out_ready(out_ready), .gnt0(gnt0), .gnt1(gnt1), .Select(Select),
    .out(out), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  // Drive one cycle of inputs, check outputs at negedge, advance the model at posedge.
  task automatic cyc(input logic r, input logic r0, input logic [DW-1:0] d1,
                     input logic r1, input logic [DW-1:0] d2, input logic rdy);
    logic          ev;
    logic [DW-1:0] eo;
    logic [DW-1:0] pd;
    int            ns, cn;
    rst_n = r; req0 = r0; in1 = d1; req1 = r1; in2 = d2; out_ready = rdy;
    ev = r && ((m_st == 1 && r0) || (m_st == 2 && r1));
    eo = !r ? '0 : (m_st == 1 ? d1 : (m_st == 2 ? d2 : '0));
    if (ev && rdy) sb_q.push_back(m_st == 1 ? d1 : d2);
    @(negedge clk);
    chk("gnt0", {31'd0, gnt0}, {31'd0, m_st == 1});
    chk("gnt1", {31'd0, gnt1}, {31'd0, m_st == 2});
    chk("select", {31'd0, Select}, {31'd0, m_st == 2});
    chk("out_valid", {31'd0, out_valid}, {31'd0, ev});
    chk("out", {24'd0, out}, {24'd0, eo});
    if (out_valid && out_ready) begin
      if (sb_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
      else begin
        pd = sb_q.pop_front();
        chk("sb_beat", {24'd0, out}, {24'd0, pd});
      end
    end
    @(posedge clk);
    if (!r) begin
      m_st = 0; m_cnt = 0; m_last = 1;
    end else begin
      cn = (ev && rdy) ? ((m_cnt + 1 > MH) ? MH : m_cnt + 1) : m_cnt;
      ns = m_st;
      if (m_st == 0) ns = (r0 && r1) ? (m_last == 1 ? 1 : 2) : (r0 ? 1 : (r1 ? 2 : 0));
      else if (m_st == 1) ns = !r0 ? (r1 ? 2 : 0) : ((r1 && cn == MH) ? 2 : 1);
      else ns = !r1 ? (r0 ? 1 : 0) : ((r0 && cn == MH) ? 1 : 2);
      if (ns != m_st) begin
        m_cnt = 0;
        if (ns != 0) m_last = ns - 1;
      end else m_cnt = cn;
      m_st = ns;
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0; in1 = '0; in2 = '0; out_ready = 1'b0;
    @(posedge clk); #1;

    // reset state
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    cyc(0, 1, 8'h11, 1, 8'h22, 1);
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_gnt1", {31'd0, gnt1}, 32'd0);
    chk("rst_sel", {31'd0, Select}, 32'd0);

    // lone requester 0
    cyc(1, 1, 8'hA5, 0, 8'h00, 1);
    chk("solo_gnt0", {31'd0, gnt0}, 32'd1);
    chk("solo_sel", {31'd0, Select}, 32'd0);
    chk("solo_out", {24'd0, out}, 32'hA5);
    chk("solo_vld", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < 6; k++) begin
      cyc(1, 1, 8'hA5, 0, 8'h00, 1);
      chk("solo_gnt1_low", {31'd0, gnt1}, 32'd0);
    end

    // owner drops with contender waiting: direct handover
    cyc(1, 0, 8'hA5, 1, 8'h3C, 1);
    chk("hand_gnt1", {31'd0, gnt1}, 32'd1);
    chk("hand_sel", {31'd0, Select}, 32'd1);
    chk("hand_out", {24'd0, out}, 32'h3C);

    // both requesting: 4-beat alternation starting with requester 0
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    for (int k = 0; k < 16; k++) begin
      cyc(1, 1, 8'(8'h40 + k), 1, 8'(8'h80 + k), 1);
      chk("rr_sel", {31'd0, Select}, 32'((k / 4) % 2));
    end

    // stall in G0: count frozen, then exactly 4 accepted beats before rotation
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    cyc(1, 1, 8'h10, 1, 8'h20, 0);
    for (int k = 0; k < 10; k++) begin
      cyc(1, 1, 8'h10, 1, 8'h20, 0);
      chk("stall_gnt0", {31'd0, gnt0}, 32'd1);
    end
    for (int k = 1; k <= 4; k++) begin
      cyc(1, 1, 8'(8'h10 + k), 1, 8'h20, 1);
      chk("stall_rot", {31'd0, gnt1}, {31'd0, k == 4});
    end

    // reset mid-G1 after 2 beats, then requester 0 wins
    cyc(1, 1, 8'h55, 1, 8'h66, 1);
    cyc(1, 1, 8'h55, 1, 8'h67, 1);
    chk("pre_rst_g1", {31'd0, gnt1}, 32'd1);
    cyc(0, 1, 8'h55, 1, 8'h68, 1);
    chk("mid_rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
    cyc(1, 1, 8'h55, 1, 8'h69, 1);
    chk("post_rst_g0", {31'd0, gnt0}, 32'd1);

    // idle with toggling data
    cyc(0, 0, 8'h00, 0, 8'h00, 1);
    for (int k = 0; k < 6; k++) begin
      cyc(1, 0, 8'($urandom), 0, 8'($urandom), 1);
      chk("idle_vld", {31'd0, out_valid}, 32'd0);
    end

    // random traffic against the model
    for (int k = 0; k < 60; k++)
      cyc(1, 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom));

    chk("sb_drained", sb_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux2_rr_arbiter.md
Name: mux2_rr_arbiter

Overview:
- Shares one 2:1 data mux (output channel) between two requesters using round-robin arbitration with a bounded hold time.
- Drives the mux select, per-requester grants and a valid/ready output channel.
- Sits in front of the Mux2_1 datapath and sequences its Select input so neither source starves.

Parameters:
DW, 8, width of in1, in2 and out
MAX_HOLD, 4, maximum accepted beats per grant while the other requester is waiting (must be >= 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous reset, active-low; sampled on rising clk
req0  input  1  requester 0 wants the channel; data on in1
in1  input  DW  requester 0 data
req1  input  1  requester 1 wants the channel; data on in2
in2  input  DW  requester 1 data
out_ready  input  1  downstream accepts a beat this cycle
gnt0  output  1  requester 0 owns the channel (registered)
gnt1  output  1  requester 1 owns the channel (registered)
Select  output  1  mux select, 0 = in1, 1 = in2 (registered)
out  output  DW  muxed data; Select ? in2 : in1 while granted, else 0
out_valid  output  1  beat present: (gnt0 & req0) | (gnt1 & req1)

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; gnt0 = 0, gnt1 = 0, Select = 0, beat counter = 0, last-grant pointer = 1, so requester 0 wins the first tie. While in reset and the cycle after: out = 0, out_valid = 0.
- Reset asserted mid-grant aborts the grant at that edge. No beat completes in that cycle from the arbiter's point of view.
- States: IDLE, G0, G1. gnt0 = (state == G0), gnt1 = (state == G1), Select = (state == G1). Only one grant is ever high.
- IDLE transitions:
  - Only req0 goes to G0; only req1 goes to G1.
  - Both requests go to the requester other than last-grant.
  - No request stays in IDLE.
- Latency: a request first sampled high at edge N gives a grant visible after edge N. The first beat can be accepted in the cycle following edge N.
- Beat transfer: out_valid & out_ready in a cycle. The counter increments on each transfer and saturates at MAX_HOLD. out_valid and out are combinational from the registered state and the current req/in.
- G0 exit rules (G1 is symmetric):
  - req0 low at the edge with req1 high: go to G1.
  - req0 low at the edge with req1 low: go to IDLE.
  - req0 high, req1 high, and the counter value after this edge's update equals MAX_HOLD: forced rotation to G1.
  - Otherwise stay in G0. With no contender the grant holds indefinitely and the counter stays saturated.
  - A contender arriving after saturation forces rotation at the next edge.
- On every state change the counter clears to 0, and last-grant updates to the requester just granted.
- Switch cost: one grant change per edge with no IDLE bubble. Select and data change together.
- out_ready low stalls: the counter holds, and no rotation occurs unless the owner drops req.
- The requester must hold req and data stable until the beat is accepted. The arbiter does not buffer data.

Test Plan:
- Reset, then req0 = 1 alone with in1 = 8'hA5 and out_ready = 1:
  - gnt0 = 1 and Select = 0 after the first edge.
  - out = 8'hA5 and out_valid = 1 from the next cycle.
  - gnt1 stays 0.
- Both req0 = req1 = 1 from reset, out_ready = 1, MAX_HOLD = 4:
  - G0 for 4 beats, then G1 for 4 beats, alternating.
  - Select toggles every 4 cycles; the first grant goes to requester 0.
- G0 active, req0 drops while req1 = 1 (in2 = 8'h3C): next edge gnt1 = 1, Select = 1, out = 8'h3C, with no IDLE cycle.
- Both requesting, out_ready = 0 for 10 cycles during G0:
  - Grant stays G0 and the counter does not advance.
  - After out_ready returns, rotation happens after exactly 4 accepted beats.
- G1 with 2 beats accepted, rst_n low for 1 cycle, both requesting after release:
  - State IDLE, all grants 0, out = 0 during reset.
  - Then G0 wins (pointer reset to 1).
- Neither requesting: state stays IDLE, out_valid = 0, out = 0 regardless of in1/in2 toggling.
